// File: rtl/yarp_mc_ctrl_if.sv
// Control-path bundle between yarp_mc_ctrl (master) and the datapath/memory side (slave).
// Perf counter signals exist only when YARP_MC_PERF_CNT_EN is defined.
interface yarp_mc_ctrl_if;
  logic       r_type_instr_i;
  logic       i_type_instr_i;
  logic       s_type_instr_i;
  logic       b_type_instr_i;
  logic       u_type_instr_i;
  logic       j_type_instr_i;
  logic [6:0] op_i;
  logic       imem_ack_i;
  logic       dmem_ack_i;
  logic       imem_req_o;
  logic       ir_we_o;
  logic       dmem_req_o;
  logic       dmem_wr_o;
  logic       rf_we_o;
  logic       pc_we_o;
  logic       illegal_instr_o;
  logic       fetch_err_o;
  logic [2:0] state_o;
`ifdef YARP_MC_PERF_CNT_EN
  logic [63:0] cycle_cnt_o;
  logic [63:0] instret_cnt_o;
`endif

  modport master (
    input  r_type_instr_i, i_type_instr_i, s_type_instr_i, b_type_instr_i,
    input  u_type_instr_i, j_type_instr_i, op_i, imem_ack_i, dmem_ack_i,
    output imem_req_o, ir_we_o, dmem_req_o, dmem_wr_o, rf_we_o, pc_we_o,
    output illegal_instr_o, fetch_err_o, state_o
`ifdef YARP_MC_PERF_CNT_EN
    , output cycle_cnt_o, instret_cnt_o
`endif
  );

  modport slave (
    output r_type_instr_i, i_type_instr_i, s_type_instr_i, b_type_instr_i,
    output u_type_instr_i, j_type_instr_i, op_i, imem_ack_i, dmem_ack_i,
    input  imem_req_o, ir_we_o, dmem_req_o, dmem_wr_o, rf_we_o, pc_we_o,
    input  illegal_instr_o, fetch_err_o, state_o
`ifdef YARP_MC_PERF_CNT_EN
    , input cycle_cnt_o, instret_cnt_o
`endif
  );
endinterface

// File: rtl/yarp_mc_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the yarp core; holds no datapath values.
// Define YARP_MC_PERF_CNT_EN to add 64-bit cycle and retired-instruction counters.
module yarp_mc_ctrl #(
  parameter int FETCH_TIMEOUT = 16
) (
  input logic            clk,
  input logic            reset,
  yarp_mc_ctrl_if.master bus
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam int CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(FETCH_TIMEOUT);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] to_cnt;
  logic [CNT_W-1:0] to_cnt_inc;
  logic             illegal_q;
  logic             fetch_err_q;
  logic             to_hit;
  logic             ill_set;

  logic is_i, is_s, is_b, is_load, any_type;

  // Flags should be one-hot; if not, r > i > s > b > u > j decides.
  assign is_i     = !bus.r_type_instr_i && bus.i_type_instr_i;
  assign is_s     = !bus.r_type_instr_i && !bus.i_type_instr_i && bus.s_type_instr_i;
  assign is_b     = !bus.r_type_instr_i && !bus.i_type_instr_i && !bus.s_type_instr_i
                    && bus.b_type_instr_i;
  assign is_load  = is_i && (bus.op_i == 7'h03);
  assign any_type = bus.r_type_instr_i | bus.i_type_instr_i | bus.s_type_instr_i |
                    bus.b_type_instr_i | bus.u_type_instr_i | bus.j_type_instr_i;

  assign to_cnt_inc = to_cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    to_hit    = 1'b0;
    ill_set   = 1'b0;
    case (state)
      S_RESET:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ack_i) begin
          state_nxt = S_DECODE;
        end else if ((FETCH_TIMEOUT != 0) && (to_cnt_inc == TO_LIMIT)) begin
          state_nxt = S_HALT;
          to_hit    = 1'b1;
        end
      end
      S_DECODE: begin
        if (!any_type) begin
          state_nxt = S_HALT;
          ill_set   = 1'b1;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_load || is_s) state_nxt = S_MEM;
        else if (is_b)       state_nxt = S_FETCH;
        else                 state_nxt = S_WB;
      end
      S_MEM: begin
        if (bus.dmem_ack_i) state_nxt = is_s ? S_FETCH : S_WB;
      end
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RESET;
      to_cnt      <= '0;
      illegal_q   <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      // Counts consecutive un-acked FETCH cycles; any exit from FETCH restarts it.
      to_cnt      <= (state == S_FETCH && state_nxt == S_FETCH) ? to_cnt_inc : '0;
      illegal_q   <= illegal_q | ill_set;
      fetch_err_q <= fetch_err_q | to_hit;
    end
  end

  assign bus.imem_req_o      = (state == S_FETCH);
  assign bus.ir_we_o         = (state == S_FETCH) && bus.imem_ack_i;
  assign bus.dmem_req_o      = (state == S_MEM);
  assign bus.dmem_wr_o       = (state == S_MEM) && is_s;
  assign bus.rf_we_o         = (state == S_WB);
  assign bus.pc_we_o         = ((state == S_EXEC) && is_b) ||
                               ((state == S_MEM) && bus.dmem_ack_i && is_s) ||
                               (state == S_WB);
  assign bus.illegal_instr_o = illegal_q;
  assign bus.fetch_err_o     = fetch_err_q;
  assign bus.state_o         = state;

`ifdef YARP_MC_PERF_CNT_EN
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_RESET && state != S_HALT) cycle_cnt <= cycle_cnt + 64'd1;
      if (bus.pc_we_o) instret_cnt <= instret_cnt + 64'd1;
    end
  end

  assign bus.cycle_cnt_o   = cycle_cnt;
  assign bus.instret_cnt_o = instret_cnt;
`endif

endmodule

// File: tb/tb_yarp_mc_ctrl.sv
// Directed bench for yarp_mc_ctrl: driver queues per-cycle expected outputs, monitor checks them.
module tb_yarp_mc_ctrl;
  logic clk;
  logic reset;

  yarp_mc_ctrl_if bus ();

  yarp_mc_ctrl #(.FETCH_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {state, imem_req, ir_we, dmem_req, dmem_wr, rf_we, pc_we, illegal, fetch_err}
  logic [10:0] exp_q[$];
  string       nm_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam logic [5:0] FR = 6'b100000;
  localparam logic [5:0] FI = 6'b010000;
  localparam logic [5:0] FS = 6'b001000;
  localparam logic [5:0] FB = 6'b000100;
  localparam logic [5:0] FU = 6'b000010;
  localparam logic [5:0] FN = 6'b000000;

  task automatic step(input logic rst, input logic [5:0] fl, input logic [6:0] op,
                      input logic ia, input logic da, input logic chk,
                      input logic [2:0] st, input logic [7:0] b, input string nm);
    reset = rst;
    {bus.r_type_instr_i, bus.i_type_instr_i, bus.s_type_instr_i,
     bus.b_type_instr_i, bus.u_type_instr_i, bus.j_type_instr_i} = fl;
    bus.op_i       = op;
    bus.imem_ack_i = ia;
    bus.dmem_ack_i = da;
    if (chk) begin
      exp_q.push_back({st, b});
      nm_q.push_back(nm);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation.
  initial begin
    logic [10:0] act;
    logic [10:0] exp;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = nm_q.pop_front();
        act = {bus.state_o, bus.imem_req_o, bus.ir_we_o, bus.dmem_req_o, bus.dmem_wr_o,
               bus.rf_we_o, bus.pc_we_o, bus.illegal_instr_o, bus.fetch_err_o};
        n_cmp++;
        if (act !== exp) begin
          n_bad++;
          $display("FAIL %s: got st=%0d strobes=%b, expected st=%0d strobes=%b",
                   nm, act[10:8], act[7:0], exp[10:8], exp[7:0]);
        end
      end
    end
  end

  initial begin
    step(1, FN, 7'h00, 0, 0, 0, 3'd0, 8'b0, "");
    step(1, FN, 7'h00, 0, 0, 1, 3'd0, 8'b0000_0000, "rst_hold");
    step(0, FN, 7'h00, 0, 0, 1, 3'd0, 8'b0000_0000, "rst_release");

    // R-type, zero-wait memories
    step(0, FR, 7'h33, 1, 1, 1, 3'd1, 8'b1100_0000, "r_fetch");
    step(0, FR, 7'h33, 0, 0, 1, 3'd2, 8'b0000_0000, "r_decode");
    step(0, FR, 7'h33, 0, 0, 1, 3'd3, 8'b0000_0000, "r_exec");
    step(0, FR, 7'h33, 0, 0, 1, 3'd5, 8'b0000_1100, "r_wb");

    // Load with dmem ack delayed 3 cycles
    step(0, FI, 7'h03, 1, 0, 1, 3'd1, 8'b1100_0000, "ld_fetch");
    step(0, FI, 7'h03, 0, 0, 1, 3'd2, 8'b0000_0000, "ld_decode");
    step(0, FI, 7'h03, 0, 0, 1, 3'd3, 8'b0000_0000, "ld_exec");
    for (int i = 0; i < 3; i++)
      step(0, FI, 7'h03, 0, 0, 1, 3'd4, 8'b0010_0000, "ld_mem_wait");
    step(0, FI, 7'h03, 0, 1, 1, 3'd4, 8'b0010_0000, "ld_mem_ack");
    step(0, FI, 7'h03, 0, 0, 1, 3'd5, 8'b0000_1100, "ld_wb");

    // Store, one wait cycle
    step(0, FS, 7'h23, 1, 0, 1, 3'd1, 8'b1100_0000, "st_fetch");
    step(0, FS, 7'h23, 0, 0, 1, 3'd2, 8'b0000_0000, "st_decode");
    step(0, FS, 7'h23, 0, 0, 1, 3'd3, 8'b0000_0000, "st_exec");
    step(0, FS, 7'h23, 0, 0, 1, 3'd4, 8'b0011_0000, "st_mem_wait");
    step(0, FS, 7'h23, 0, 1, 1, 3'd4, 8'b0011_0100, "st_mem_ack");

    // Branch retires from EXEC
    step(0, FB, 7'h63, 1, 0, 1, 3'd1, 8'b1100_0000, "br_fetch");
    step(0, FB, 7'h63, 0, 0, 1, 3'd2, 8'b0000_0000, "br_decode");
    step(0, FB, 7'h63, 0, 0, 1, 3'd3, 8'b0000_0100, "br_exec");

    // U-type goes through WB
    step(0, FU, 7'h37, 1, 0, 1, 3'd1, 8'b1100_0000, "u_fetch");
    step(0, FU, 7'h37, 0, 0, 1, 3'd2, 8'b0000_0000, "u_decode");
    step(0, FU, 7'h37, 0, 0, 1, 3'd3, 8'b0000_0000, "u_exec");
    step(0, FU, 7'h37, 0, 0, 1, 3'd5, 8'b0000_1100, "u_wb");

    // r+s set: r wins, no MEM visit
    step(0, FR | FS, 7'h33, 1, 0, 1, 3'd1, 8'b1100_0000, "prs_fetch");
    step(0, FR | FS, 7'h33, 0, 0, 1, 3'd2, 8'b0000_0000, "prs_decode");
    step(0, FR | FS, 7'h33, 0, 0, 1, 3'd3, 8'b0000_0000, "prs_exec");
    step(0, FR | FS, 7'h33, 0, 0, 1, 3'd5, 8'b0000_1100, "prs_wb");

    // i+s set with load opcode: behaves as a load (read, then WB)
    step(0, FI | FS, 7'h03, 1, 0, 1, 3'd1, 8'b1100_0000, "pis_fetch");
    step(0, FI | FS, 7'h03, 0, 0, 1, 3'd2, 8'b0000_0000, "pis_decode");
    step(0, FI | FS, 7'h03, 0, 0, 1, 3'd3, 8'b0000_0000, "pis_exec");
    step(0, FI | FS, 7'h03, 0, 1, 1, 3'd4, 8'b0010_0000, "pis_mem");
    step(0, FI | FS, 7'h03, 0, 0, 1, 3'd5, 8'b0000_1100, "pis_wb");

    // I-type ALU with slow fetch; stray acks outside FETCH/MEM are ignored
    step(0, FI, 7'h13, 0, 0, 1, 3'd1, 8'b1000_0000, "ia_fetch_wait");
    step(0, FI, 7'h13, 0, 1, 1, 3'd1, 8'b1000_0000, "ia_fetch_wait2");
    step(0, FI, 7'h13, 1, 0, 1, 3'd1, 8'b1100_0000, "ia_fetch");
    step(0, FI, 7'h13, 1, 1, 1, 3'd2, 8'b0000_0000, "ia_decode_stray");
    step(0, FI, 7'h13, 1, 1, 1, 3'd3, 8'b0000_0000, "ia_exec_stray");
    step(0, FI, 7'h13, 0, 0, 1, 3'd5, 8'b0000_1100, "ia_wb");

    // Illegal: no type flags
    step(0, FN, 7'h7F, 1, 0, 1, 3'd1, 8'b1100_0000, "ill_fetch");
    step(0, FN, 7'h7F, 0, 0, 1, 3'd2, 8'b0000_0000, "ill_decode");
    for (int i = 0; i < 20; i++)
      step(0, FN, 7'h7F, i[0], i[1], 1, 3'd6, 8'b0000_0010, "ill_halt");
    step(1, FN, 7'h7F, 0, 0, 1, 3'd6, 8'b0000_0010, "ill_rst_edge");
    step(0, FN, 7'h00, 0, 0, 1, 3'd0, 8'b0000_0000, "ill_cleared");

    // Fetch timeout: 16 un-acked FETCH cycles, then HALT with fetch_err
    for (int i = 0; i < 16; i++)
      step(0, FR, 7'h33, 0, 0, 1, 3'd1, 8'b1000_0000, "to_fetch");
    for (int i = 0; i < 3; i++)
      step(0, FR, 7'h33, 1, 1, 1, 3'd6, 8'b0000_0001, "to_halt");
    step(1, FR, 7'h33, 0, 0, 1, 3'd6, 8'b0000_0001, "to_rst_edge");
    step(0, FR, 7'h33, 0, 0, 1, 3'd0, 8'b0000_0000, "to_cleared");

    // Reset while stalled in MEM
    step(0, FI, 7'h03, 1, 0, 1, 3'd1, 8'b1100_0000, "mr_fetch");
    step(0, FI, 7'h03, 0, 0, 1, 3'd2, 8'b0000_0000, "mr_decode");
    step(0, FI, 7'h03, 0, 0, 1, 3'd3, 8'b0000_0000, "mr_exec");
    step(0, FI, 7'h03, 0, 0, 1, 3'd4, 8'b0010_0000, "mr_mem");
    step(1, FI, 7'h03, 0, 1, 1, 3'd4, 8'b0010_0000, "mr_mem_rst");
    step(0, FI, 7'h03, 0, 1, 1, 3'd0, 8'b0000_0000, "mr_reset_state");
    step(0, FI, 7'h03, 0, 0, 1, 3'd1, 8'b1000_0000, "mr_refetch");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
      n_bad += exp_q.size();
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
